// File: rtl/riscv_dbus_arb.sv
// riscv_dbus_arb: round-robin two-master arbiter and sequencer for a single word-addressed data memory port.
// Ports: clk_i/rst_ni clock and async active-low reset; mN_* request/response channel per master
// (req/we/byte/addr/wdata in, ack/err/rdata out); mem_req_o/addr_mem_o/dat_mem_o/mem_we drive the
// memory phase; data_mem_i/dbus_ack_i return read data and phase completion.
module riscv_dbus_arb #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        m0_req_i,
  input  logic        m0_we_i,
  input  logic        m0_byte_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_wdata_i,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  output logic [31:0] m0_rdata_o,
  input  logic        m1_req_i,
  input  logic        m1_we_i,
  input  logic        m1_byte_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_wdata_i,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic [31:0] m1_rdata_o,
  output logic        mem_req_o,
  output logic [29:0] addr_mem_o,
  output logic [31:0] dat_mem_o,
  output logic        mem_we,
  input  logic [31:0] data_mem_i,
  input  logic        dbus_ack_i
);
  typedef enum logic [2:0] {IDLE, RD, WR, RMW_RD, RMW_WR, RESP} state_t;
  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_gnt, r_last, r_byte, r_ack, r_err;
  logic [1:0]    r_lane;
  logic [7:0]    r_wb;
  logic [31:0]   r_rdata;
  logic          w_req, w_pick, w_we, w_byte, w_tmo;
  logic [31:0]   w_addr, w_wdata, w_merge;
  logic [7:0]    w_lane_rd;
  logic [4:0]    w_sh;
  assign w_req   = m0_req_i | m1_req_i;
  // on a tie the master not granted last wins; a lone requester always wins
  assign w_pick  = (m0_req_i & m1_req_i) ? ~r_last : m1_req_i;
  assign w_we    = w_pick ? m1_we_i    : m0_we_i;
  assign w_byte  = w_pick ? m1_byte_i  : m0_byte_i;
  assign w_addr  = w_pick ? m1_addr_i  : m0_addr_i;
  assign w_wdata = w_pick ? m1_wdata_i : m0_wdata_i;
  assign w_sh    = {r_lane, 3'b000};
  assign w_lane_rd = 8'(data_mem_i >> w_sh);
  assign w_merge = (data_mem_i & ~(32'h0000_00ff << w_sh)) | ({24'b0, r_wb} << w_sh);
  // counter value TIMEOUT-1 means this is the TIMEOUT-th phase cycle
  assign w_tmo   = (TIMEOUT != 0) && (r_cnt == CW'(TIMEOUT - 1));
  assign m0_ack_o   = r_ack & ~r_gnt;
  assign m1_ack_o   = r_ack & r_gnt;
  assign m0_err_o   = m0_ack_o & r_err;
  assign m1_err_o   = m1_ack_o & r_err;
  assign m0_rdata_o = m0_ack_o ? r_rdata : '0;
  assign m1_rdata_o = m1_ack_o ? r_rdata : '0;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_gnt      <= 1'b0;
      r_last     <= 1'b1;
      r_byte     <= 1'b0;
      r_ack      <= 1'b0;
      r_err      <= 1'b0;
      r_lane     <= '0;
      r_wb       <= '0;
      r_rdata    <= '0;
      mem_req_o  <= 1'b0;
      mem_we     <= 1'b0;
      addr_mem_o <= '0;
      dat_mem_o  <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_req) begin
          r_gnt      <= w_pick;
          r_byte     <= w_byte;
          r_lane     <= w_addr[1:0];
          r_wb       <= w_wdata[7:0];
          r_cnt      <= '0;
          r_rdata    <= '0;
          r_err      <= 1'b0;
          addr_mem_o <= w_addr[31:2];
          mem_req_o  <= 1'b1;
          mem_we     <= w_we & ~w_byte;
          if (w_we & ~w_byte) dat_mem_o <= w_wdata;
          r_state    <= w_we ? (w_byte ? RMW_RD : WR) : RD;
        end
        RD, WR, RMW_RD, RMW_WR: if (dbus_ack_i) begin
          r_cnt <= '0;
          if (r_state == RMW_RD) begin
            // memory has no byte enables: write back the read word with one lane replaced
            dat_mem_o <= w_merge;
            mem_we    <= 1'b1;
            r_state   <= RMW_WR;
          end else begin
            mem_req_o <= 1'b0;
            mem_we    <= 1'b0;
            r_ack     <= 1'b1;
            r_state   <= RESP;
            if (r_state == RD) r_rdata <= r_byte ? {24'b0, w_lane_rd} : data_mem_i;
          end
        end else if (w_tmo) begin
          mem_req_o <= 1'b0;
          mem_we    <= 1'b0;
          r_ack     <= 1'b1;
          r_err     <= 1'b1;
          r_rdata   <= '0;
          r_state   <= RESP;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
        RESP: begin
          r_ack   <= 1'b0;
          r_last  <= r_gnt;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/riscv_dbus_arb.md
# riscv_dbus_arb

Two-master data-bus arbiter and sequencer in front of the single-ported data memory interface. It grants the core load/store unit (m0) and a secondary master such as debug or DMA (m1) round-robin access to one word-addressed memory port. Each granted transaction runs through a state machine that handles word reads and writes, zero-extended byte reads, and byte stores. The memory has no byte enables, so byte stores are performed as read-modify-write. A per-phase timeout converts a missing memory acknowledge into an error response instead of a bus hang.

## Interface
- TIMEOUT, 255: max cycles a memory phase waits for `dbus_ack_i`; 0 disables timeout.
- clk_i  in  1  single clock, rising edge.
- rst_ni  in  1  reset, asynchronous assert, active-low.
- m0_req_i, m1_req_i  in  1  transaction request; held with fields stable until the matching `mN_ack_o`.
- m0_we_i, m1_we_i  in  1  1 = store, 0 = load.
- m0_byte_i, m1_byte_i  in  1  1 = byte access at lane `addr[1:0]`, 0 = word access.
- m0_addr_i, m1_addr_i  in  32  byte address; `[1:0]` ignored for word accesses.
- m0_wdata_i, m1_wdata_i  in  32  store data; byte stores use `[7:0]`.
- m0_ack_o, m1_ack_o  out  1  one-cycle completion pulse.
- m0_err_o, m1_err_o  out  1  valid with ack; 1 = timed out.
- m0_rdata_o, m1_rdata_o  out  32  load data, valid with ack.
- mem_req_o  out  1  memory phase active.
- addr_mem_o  out  30  word address `[31:2]`.
- dat_mem_o  out  32  write data.
- mem_we  out  1  write phase.
- data_mem_i  in  32  read data, valid with `dbus_ack_i`.
- dbus_ack_i  in  1  memory phase completion; ignored while `mem_req_o` = 0.

## Operation
- States: IDLE, RD, WR, RMW_RD, RMW_WR, RESP.
- **Arbitration (IDLE only).**
  - Only one requester active: it wins.
  - Both active: the master that was not granted last wins.
  - The `last` pointer resets to m1, so m0 wins the first tie.
  - The grant is locked until RESP completes; there is no preemption.
- **IDLE to phase.** On grant, latch the winner's we, byte, addr and wdata, then go to:
  - word load: RD
  - byte load: RD
  - word store: WR, `dat_mem_o` = wdata
  - byte store: RMW_RD
- **RD.** Drive `mem_req_o` = 1, `mem_we` = 0. On `dbus_ack_i`, capture the read data and go to RESP.
  - Word load: rdata = `data_mem_i`.
  - Byte load: rdata = {24'b0, selected lane}, where lane k = `data_mem_i[8k+7:8k]`.
- **RMW_RD.** On ack, load `dat_mem_o` with `data_mem_i`, lane k replaced by `wdata[7:0]`. Go to RMW_WR.
- **WR / RMW_WR.** Drive `mem_req_o` = 1, `mem_we` = 1. On ack, go to RESP.
- **RESP.** Pulse the granted `mN_ack_o` for one cycle with rdata/err, update `last`, return to IDLE.
- **Timeout.**
  - The counter clears on entry to every phase and increments each phase cycle without ack.
  - When it reaches TIMEOUT with no ack: abort to RESP with err = 1, rdata = 0. No write phase is issued after an aborted RMW_RD.
  - An ack in the same cycle as the limit counts as success.
- **Requester dropping req mid-transaction.** Ignored; the transaction completes and the ack is still pulsed.
- **Reset (any time, including mid-phase).** All outputs go to 0 immediately, FSM goes to IDLE, `last` = m1, counter = 0.

## Timing
- Request sampled in IDLE at cycle 0.
- Memory phase drives from cycle 1.
- Zero-wait memory (ack in first phase cycle):
  - word load/store: `mN_ack_o` at cycle 2
  - byte store: RMW_RD at cycle 1, RMW_WR at cycle 2, ack at cycle 3
- Each wait cycle adds one cycle of latency.
- `mem_req_o` stays high across RMW_RD to RMW_WR; `addr_mem_o` is unchanged and `mem_we` rises. Each ack closes exactly one phase.
- Back-to-back: the next grant is evaluated in the IDLE cycle after RESP, giving a minimum 3-cycle issue interval.
- `dat_mem_o` changes only on entry to WR or RMW_WR; it otherwise holds its value.

## Test plan
- **Word store then load.** m0 stores 0xDEADBEEF to 0x100 with zero-wait memory → `addr_mem_o` = 0x40, `mem_we` = 1 at cycle 1, `m0_ack_o` at cycle 2. A load from 0x100 → `m0_rdata_o` = 0xDEADBEEF.
- **Byte store RMW.** Memory word = 0x11223344; m1 byte-stores 0xAA to addr 0x102 → read phase, then write phase with `dat_mem_o` = 0x11AA3344, `m1_ack_o` at cycle 3. A byte load from 0x102 → rdata = 0x000000AA.
- **Simultaneous requests.** m0 and m1 request together repeatedly → grants alternate m0, m1, m0, …. With m0 requesting alone → m0 is granted every transaction.
- **Timeout.** TIMEOUT = 4 with memory never acking a load → `mem_req_o` high for 4 cycles, then `m0_ack_o` = 1 with `m0_err_o` = 1 and rdata = 0. A byte store under the same memory → no write phase issued.
- **Ack at limit.** TIMEOUT = 4 with ack arriving in the 4th phase cycle → `err_o` = 0.
- **Reset mid-RMW.** Assert `rst_ni` low during RMW_WR → `mem_req_o`, `mem_we`, `dat_mem_o` and all acks go to 0 asynchronously. After release, a tie goes to m0.
